// File: rtl/mux2_arb_pkg.sv
// ============================================================================
// Module   : mux2_arb_pkg
// Purpose  : Shared state encodings and default sizing for mux2_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux2_arb_pkg;

  localparam int c_default_width    = 8;
  localparam int c_default_hold_max = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

endpackage : mux2_arb_pkg

`default_nettype wire

// File: rtl/mux2_arbiter_mux2.sv
// ============================================================================
// Module   : mux2
// Purpose  : One-bit 2:1 multiplexer; s=0 selects d0, s=1 selects d1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule : mux2

`default_nettype wire

// File: rtl/mux2_arbiter.sv
// ============================================================================
// Module   : mux2_arbiter
// Purpose  : Burst-locked round-robin arbiter sharing a 2:1 mux between two
//            valid/ready requesters. Optional per-grant beat limit enabled by
//            defining MUX2_ARB_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = c_default_width,
  parameter int HOLD_MAX = c_default_hold_max
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             ack1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  if (WIDTH < 1 || HOLD_MAX < 1) begin : g_param_check
    $error("mux2_arbiter: WIDTH and HOLD_MAX must be >= 1");
  end

  state_t r_state;
  state_t w_state_next;
  logic   r_sel;
  logic   r_rr_ptr;
  logic   w_release;
  logic   w_hold_hit;

  logic [WIDTH:0] w_mux_in0;
  logic [WIDTH:0] w_mux_in1;
  logic [WIDTH:0] w_mux_out;

  // Last flag rides the same mux as the data, in the top bit.
  assign w_mux_in0 = {last0, data0};
  assign w_mux_in1 = {last1, data1};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_mux_bit
    mux2 u_mux2 (
      .d0 (w_mux_in0[i]),
      .d1 (w_mux_in1[i]),
      .s  (r_sel),
      .y  (w_mux_out[i])
    );
  end

  assign out_data = w_mux_out[WIDTH-1:0];
  assign out_last = w_mux_out[WIDTH];
  assign sel      = r_sel;
  assign busy     = (r_state != IDLE);

`ifdef MUX2_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_beat_cnt;

  assign w_hold_hit = (r_beat_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_release || w_state_next == IDLE) begin
      r_beat_cnt <= '0;
    end else if (ack0 || ack1) begin
      r_beat_cnt <= w_hold_hit ? '0 : r_beat_cnt + 1'b1;
    end
  end
`else
  assign w_hold_hit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_release    = 1'b0;
    out_valid    = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 && req1)  w_state_next = r_rr_ptr ? GNT0 : GNT1;
        else if (req0)     w_state_next = GNT0;
        else if (req1)     w_state_next = GNT1;
      end
      GNT0: begin
        out_valid = req0;
        ack0      = req0 & out_ready;
        if (!req0) begin
          w_state_next = IDLE;
        end else if (ack0 && (last0 || (w_hold_hit && req1))) begin
          w_release    = 1'b1;
          w_state_next = req1 ? GNT1 : GNT0;
        end
      end
      GNT1: begin
        out_valid = req1;
        ack1      = req1 & out_ready;
        if (!req1) begin
          w_state_next = IDLE;
        end else if (ack1 && (last1 || (w_hold_hit && req0))) begin
          w_release    = 1'b1;
          w_state_next = req0 ? GNT0 : GNT1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Select is registered alongside the state; it keeps its value through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= 1'b0;
      r_rr_ptr <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == GNT1)      r_sel <= 1'b1;
      else if (w_state_next == GNT0) r_sel <= 1'b0;
      if (w_release) r_rr_ptr <= (r_state == GNT1);
    end
  end

endmodule : mux2_arbiter

`default_nettype wire
